// File: rtl/vga_axil2native_pkg.sv
// Shared types, response codes and FSM state encodings for the AXI-Lite to
// native register bridge.
package vga_axil_pkg;

  localparam int DEF_AXIL_ADDR_W   = 32;
  localparam int DEF_AXIL_DATA_W   = 32;
  localparam int DEF_NATIVE_ADDR_W = 4;

  typedef logic [DEF_AXIL_ADDR_W-1:0]   axil_addr_t;
  typedef logic [DEF_AXIL_DATA_W-1:0]   axil_data_t;
  typedef logic [DEF_NATIVE_ADDR_W-1:0] native_addr_t;
  typedef logic [1:0]                   resp_t;

  localparam resp_t OKAY   = 2'b00;
  localparam resp_t SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_EXEC, R_WAIT, R_RESP} rd_state_e;

  function automatic resp_t resp_for(input logic err);
    return err ? SLVERR : OKAY;
  endfunction

endpackage

// File: rtl/vga_axil2native_if.sv
// AXI-Lite slave channel bundle; the bridge takes the slave modport, the
// upstream bus driver takes the master modport.
interface vga_axil2native_if #(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32
);
  logic [AXIL_ADDR_W-1:0] s_awaddr;
  logic                   s_awvalid;
  logic                   s_awready;
  logic [AXIL_DATA_W-1:0] s_wdata;
  logic                   s_wvalid;
  logic                   s_wready;
  logic [1:0]             s_bresp;
  logic                   s_bvalid;
  logic                   s_bready;
  logic [AXIL_ADDR_W-1:0] s_araddr;
  logic                   s_arvalid;
  logic                   s_arready;
  logic [AXIL_DATA_W-1:0] s_rdata;
  logic [1:0]             s_rresp;
  logic                   s_rvalid;
  logic                   s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/vga_axil2native.sv
// AXI-Lite slave driving a native one-strobe register port with independent
// read and write FSMs. Define VGA_AXIL_ADDR_CHECK_EN to reject out-of-range addresses.
module vga_axil2native
  import vga_axil_pkg::*;
#(
  parameter int NATIVE_ADDR_W = 4,
  parameter int AXIL_ADDR_W   = 32,
  parameter int AXIL_DATA_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  vga_axil2native_if.slave         s,
  output logic [NATIVE_ADDR_W-1:0] addr_write,
  output logic [AXIL_DATA_W-1:0]   data2native,
  output logic                     write_en,
  output logic [NATIVE_ADDR_W-1:0] addr_read,
  output logic                     read_en_sync,
  input  logic [AXIL_DATA_W-1:0]   data2axil
);

`ifdef VGA_AXIL_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  function automatic logic addr_bad(input logic [AXIL_ADDR_W-1:0] a);
    return ADDR_CHECK && (|a[AXIL_ADDR_W-1:NATIVE_ADDR_W+2]);
  endfunction

  // Byte-offset bits carry no information for word registers.
  logic unused_byte_offset;
  assign unused_byte_offset = ^{s.s_awaddr[1:0], s.s_araddr[1:0]};

  // ---------------- write channel ----------------
  wr_state_e                wr_state_q;
  logic                     awready_q, wready_q, bvalid_q;
  logic                     aw_held_q, w_held_q, aw_err_q, write_en_q;
  resp_t                    bresp_q;
  logic [NATIVE_ADDR_W-1:0] addr_write_q;
  logic [AXIL_DATA_W-1:0]   data2native_q;

  logic aw_hs, w_hs, aw_held_d, w_held_d, aw_err_d;

  // NOTE: every variable driven in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    aw_hs     = s.s_awvalid & awready_q;
    w_hs      = s.s_wvalid & wready_q;
    aw_held_d = aw_held_q | aw_hs;
    w_held_d  = w_held_q | w_hs;
    aw_err_d  = aw_hs ? addr_bad(s.s_awaddr) : aw_err_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q    <= W_IDLE;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      bresp_q       <= OKAY;
      aw_held_q     <= 1'b0;
      w_held_q      <= 1'b0;
      aw_err_q      <= 1'b0;
      write_en_q    <= 1'b0;
      addr_write_q  <= '0;
      data2native_q <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            addr_write_q <= s.s_awaddr[NATIVE_ADDR_W+1:2];
            aw_err_q     <= aw_err_d;
          end
          if (w_hs) data2native_q <= s.s_wdata;
          if (aw_held_d && w_held_d) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            write_en_q <= !aw_err_d;
            wr_state_q <= W_EXEC;
          end else begin
            // Each ready stays low once its beat is captured.
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= !aw_held_d;
            wready_q  <= !w_held_d;
          end
        end
        W_EXEC: begin
          write_en_q <= 1'b0;
          bvalid_q   <= 1'b1;
          bresp_q    <= resp_for(aw_err_q);
          wr_state_q <= W_RESP;
        end
        W_RESP: begin
          if (s.s_bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // ---------------- read channel ----------------
  rd_state_e                rd_state_q;
  logic                     arready_q, rvalid_q, ar_err_q, read_en_q;
  resp_t                    rresp_q;
  logic [NATIVE_ADDR_W-1:0] addr_read_q;
  logic [AXIL_DATA_W-1:0]   rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q  <= R_IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rresp_q     <= OKAY;
      ar_err_q    <= 1'b0;
      read_en_q   <= 1'b0;
      addr_read_q <= '0;
      rdata_q     <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (s.s_arvalid && arready_q) begin
            addr_read_q <= s.s_araddr[NATIVE_ADDR_W+1:2];
            ar_err_q    <= addr_bad(s.s_araddr);
            read_en_q   <= !addr_bad(s.s_araddr);
            arready_q   <= 1'b0;
            rd_state_q  <= R_EXEC;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_EXEC: begin
          read_en_q  <= 1'b0;
          rd_state_q <= R_WAIT;
        end
        R_WAIT: begin
          // Native data is valid the cycle after the read strobe.
          rdata_q    <= ar_err_q ? '0 : data2axil;
          rresp_q    <= resp_for(ar_err_q);
          rvalid_q   <= 1'b1;
          rd_state_q <= R_RESP;
        end
        R_RESP: begin
          if (s.s_rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign s.s_awready   = awready_q;
  assign s.s_wready    = wready_q;
  assign s.s_bvalid    = bvalid_q;
  assign s.s_bresp     = bresp_q;
  assign s.s_arready   = arready_q;
  assign s.s_rvalid    = rvalid_q;
  assign s.s_rresp     = rresp_q;
  assign s.s_rdata     = rdata_q;
  assign addr_write    = addr_write_q;
  assign data2native   = data2native_q;
  assign write_en      = write_en_q;
  assign addr_read     = addr_read_q;
  assign read_en_sync  = read_en_q;

endmodule

// File: tb/tb_vga_axil2native.sv
// Directed bench for vga_axil2native with a small native register-file model;
// expectations follow VGA_AXIL_ADDR_CHECK_EN when it is defined.
module tb_vga_axil2native;
  import vga_axil_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  addr_write, addr_read;
  logic [31:0] data2native, data2axil;
  logic        write_en, read_en_sync;

  logic [31:0] mem [16];
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  int we0, re0;

  vga_axil2native_if #(.AXIL_ADDR_W(32), .AXIL_DATA_W(32)) bus ();

  vga_axil2native #(
    .NATIVE_ADDR_W(4),
    .AXIL_ADDR_W  (32),
    .AXIL_DATA_W  (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s           (bus),
    .addr_write  (addr_write),
    .data2native (data2native),
    .write_en    (write_en),
    .addr_read   (addr_read),
    .read_en_sync(read_en_sync),
    .data2axil   (data2axil)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then act as the native register file: a read strobe
  // returns the pre-write contents, a write strobe updates the array.
  task automatic tick();
    @(posedge clk);
    #1;
    if (read_en_sync) begin
      data2axil = mem[addr_read];
      re_cnt++;
    end
    if (write_en) begin
      mem[addr_write] = data2native;
      we_cnt++;
    end
  endtask

  task automatic idle_bus();
    bus.s_awaddr  = '0; bus.s_awvalid = 1'b0;
    bus.s_wdata   = '0; bus.s_wvalid  = 1'b0;
    bus.s_araddr  = '0; bus.s_arvalid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0A00 + i;
    mem[1] = 32'hA5A5_0001;
    mem[3] = 32'h1234_5678;
    data2axil = '0;
    idle_bus();
    bus.s_bready = 1'b0;
    bus.s_rready = 1'b0;
    rst = 1'b1;

    // Reset state
    tick(); tick(); tick();
    check("rst_readies", {29'd0, bus.s_awready, bus.s_wready, bus.s_arready}, 32'd0);
    check("rst_valids",  {28'd0, bus.s_bvalid, bus.s_rvalid, write_en, read_en_sync}, 32'd0);
    check("rst_resp",    {28'd0, bus.s_bresp, bus.s_rresp}, 32'd0);
    check("rst_rdata",   bus.s_rdata, 32'd0);
    check("rst_native",  {24'd0, addr_write, addr_read}, 32'd0);
    check("rst_wdata",   data2native, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_readies", {29'd0, bus.s_awready, bus.s_wready, bus.s_arready}, 32'd7);

    // AW at cycle 0, W at cycle 3
    bus.s_awaddr = 32'h08; bus.s_awvalid = 1'b1;
    tick();
    bus.s_awvalid = 1'b0;
    check("aw_first_readies", {30'd0, bus.s_awready, bus.s_wready}, 32'd1);
    tick(); tick();
    bus.s_wdata = 32'hDEAD_BEEF; bus.s_wvalid = 1'b1;
    tick();
    bus.s_wvalid = 1'b0;
    check("aw_first_we",    {31'd0, write_en}, 32'd1);
    check("aw_first_addr",  {28'd0, addr_write}, 32'd2);
    check("aw_first_data",  data2native, 32'hDEAD_BEEF);
    check("aw_first_bv_c4", {31'd0, bus.s_bvalid}, 32'd0);
    tick();
    check("aw_first_bvalid", {31'd0, bus.s_bvalid}, 32'd1);
    check("aw_first_bresp",  {30'd0, bus.s_bresp}, {30'd0, OKAY});
    check("aw_first_we_off", {31'd0, write_en}, 32'd0);
    bus.s_bready = 1'b1;
    tick();
    bus.s_bready = 1'b0;
    check("aw_first_b_done", {29'd0, bus.s_bvalid, bus.s_awready, bus.s_wready}, 32'd3);

    // Read 0x0C, rvalid three cycles after AR
    bus.s_araddr = 32'h0C; bus.s_arvalid = 1'b1;
    tick();
    bus.s_arvalid = 1'b0;
    check("rd_ren",   {31'd0, read_en_sync}, 32'd1);
    check("rd_addr",  {28'd0, addr_read}, 32'd3);
    check("rd_arrdy", {31'd0, bus.s_arready}, 32'd0);
    tick();
    check("rd_rv_n2", {30'd0, bus.s_rvalid, read_en_sync}, 32'd0);
    tick();
    check("rd_rvalid", {31'd0, bus.s_rvalid}, 32'd1);
    check("rd_rdata",  bus.s_rdata, 32'h1234_5678);
    check("rd_rresp",  {30'd0, bus.s_rresp}, {30'd0, OKAY});
    bus.s_rready = 1'b1;
    tick();
    bus.s_rready = 1'b0;
    check("rd_done", {30'd0, bus.s_rvalid, bus.s_arready}, 32'd1);

    // Backpressure: both responses held for 10 cycles, new requests refused
    we0 = we_cnt; re0 = re_cnt;
    bus.s_awaddr = 32'h18; bus.s_awvalid = 1'b1;
    bus.s_wdata  = 32'h0000_1111; bus.s_wvalid = 1'b1;
    bus.s_araddr = 32'h0C; bus.s_arvalid = 1'b1;
    tick();
    idle_bus();
    tick(); tick();
    bus.s_awaddr = 32'h1C; bus.s_awvalid = 1'b1;
    bus.s_wdata  = 32'h0000_2222; bus.s_wvalid = 1'b1;
    bus.s_araddr = 32'h1C; bus.s_arvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valids",  {30'd0, bus.s_bvalid, bus.s_rvalid}, 32'd3);
      check("bp_rdata",   bus.s_rdata, 32'h1234_5678);
      check("bp_bresp",   {30'd0, bus.s_bresp}, {30'd0, OKAY});
      check("bp_readies", {29'd0, bus.s_awready, bus.s_wready, bus.s_arready}, 32'd0);
    end
    idle_bus();
    bus.s_bready = 1'b1; bus.s_rready = 1'b1;
    tick();
    bus.s_bready = 1'b0; bus.s_rready = 1'b0;
    check("bp_released", {27'd0, bus.s_bvalid, bus.s_rvalid, bus.s_awready, bus.s_wready, bus.s_arready}, 32'd7);
    check("bp_we_count", we_cnt - we0, 32'd1);
    check("bp_re_count", re_cnt - re0, 32'd1);
    check("bp_mem6",     mem[6], 32'h0000_1111);

    // Simultaneous AW+W+AR to the same address 0x04
    bus.s_bready = 1'b1; bus.s_rready = 1'b1;
    bus.s_awaddr = 32'h04; bus.s_awvalid = 1'b1;
    bus.s_wdata  = 32'hCAFE_0004; bus.s_wvalid = 1'b1;
    bus.s_araddr = 32'h04; bus.s_arvalid = 1'b1;
    tick();
    idle_bus();
    check("same_strobes", {30'd0, write_en, read_en_sync}, 32'd3);
    check("same_addrs",   {24'd0, addr_write, addr_read}, 32'h11);
    tick();
    check("same_bvalid", {30'd0, bus.s_bvalid, bus.s_rvalid}, 32'd2);
    tick();
    check("same_rvalid", {30'd0, bus.s_bvalid, bus.s_rvalid}, 32'd1);
    check("same_rdata",  bus.s_rdata, 32'hA5A5_0001);
    tick();
    check("same_done", {27'd0, bus.s_bvalid, bus.s_rvalid, bus.s_awready, bus.s_wready, bus.s_arready}, 32'd7);
    bus.s_araddr = 32'h04; bus.s_arvalid = 1'b1;
    tick();
    idle_bus();
    tick(); tick();
    check("same_readback", bus.s_rdata, 32'hCAFE_0004);
    tick();
    bus.s_bready = 1'b0; bus.s_rready = 1'b0;

    // Address outside the native window
    bus.s_awaddr = 32'h100; bus.s_awvalid = 1'b1;
    bus.s_wdata  = 32'h0000_0077; bus.s_wvalid = 1'b1;
    bus.s_araddr = 32'h100; bus.s_arvalid = 1'b1;
    tick();
    idle_bus();
`ifdef VGA_AXIL_ADDR_CHECK_EN
    check("oob_strobes", {30'd0, write_en, read_en_sync}, 32'd0);
`else
    check("oob_strobes", {30'd0, write_en, read_en_sync}, 32'd3);
    check("oob_addrs",   {24'd0, addr_write, addr_read}, 32'd0);
`endif
    tick();
    check("oob_bvalid", {31'd0, bus.s_bvalid}, 32'd1);
`ifdef VGA_AXIL_ADDR_CHECK_EN
    check("oob_bresp", {30'd0, bus.s_bresp}, {30'd0, SLVERR});
`else
    check("oob_bresp", {30'd0, bus.s_bresp}, {30'd0, OKAY});
`endif
    bus.s_bready = 1'b1;
    tick();
    bus.s_bready = 1'b0;
    check("oob_rvalid", {31'd0, bus.s_rvalid}, 32'd1);
`ifdef VGA_AXIL_ADDR_CHECK_EN
    check("oob_rdata", bus.s_rdata, 32'd0);
    check("oob_rresp", {30'd0, bus.s_rresp}, {30'd0, SLVERR});
`else
    check("oob_rdata", bus.s_rdata, 32'h0000_0A00);
    check("oob_rresp", {30'd0, bus.s_rresp}, {30'd0, OKAY});
`endif
    bus.s_rready = 1'b1;
    tick();
    bus.s_rready = 1'b0;

    // Reset the cycle after read_en_sync aborts the read
    re0 = re_cnt;
    bus.s_araddr = 32'h0C; bus.s_arvalid = 1'b1;
    tick();
    idle_bus();
    check("abort_ren", {31'd0, read_en_sync}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check("abort_in_rst", {29'd0, bus.s_rvalid, bus.s_arready, read_en_sync}, 32'd0);
    rst = 1'b0;
    tick();
    check("abort_readies", {29'd0, bus.s_awready, bus.s_wready, bus.s_arready}, 32'd7);
    check("abort_rvalid",  {31'd0, bus.s_rvalid}, 32'd0);
    tick(); tick(); tick();
    check("abort_no_rvalid", {30'd0, bus.s_rvalid, bus.s_bvalid}, 32'd0);
    check("abort_re_count",  re_cnt - re0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
